// File: rtl/sqrt_seq_unit.sv
// Sequential integer square-root unit: root_o = floor(sqrt(n_i)).
//
// Walks root upward by odd-number accumulation: sq tracks (root+1)^2 and
// delta tracks 2*root+3, so each step needs only adds and one compare.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   start_i  request, accepted only on an edge where ready_o=1
//   n_i      radicand, sampled on the accepting edge
//   ready_o  idle, can accept start_i
//   busy_o   computation in progress
//   done_o   one-cycle pulse, root_o valid from this cycle on
//   root_o   result, held until the next done_o
//   rem_o    n - root^2 (present only with SQRT_REMAINDER_EN defined)
//
// Optional feature macro: SQRT_REMAINDER_EN adds the rem_o port and its logic.
module sqrt_seq_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     n_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [WIDTH/2-1:0]   root_o
`ifdef SQRT_REMAINDER_EN
    ,
    output logic [WIDTH/2:0]     rem_o
`endif
);

    localparam int unsigned RW = WIDTH / 2;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StCmp  = 3'd2,
        StUpd  = 3'd3,
        StDone = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] n_q;
    logic [RW-1:0]    root_q;
    logic [WIDTH:0]   sq_q;     // (root+1)^2, reaches 2^WIDTH for the largest radicand
    logic [RW+1:0]    delta_q;  // 2*root+3
    logic             sq_le_n;

    assign sq_le_n = (sq_q <= {1'b0, n_q});

`ifdef SQRT_REMAINDER_EN
    // sq - delta + 2 = root^2; the intermediate may wrap for small roots, the sum does not.
    logic [WIDTH:0] root_sq;
    logic [WIDTH:0] rem_full;
    assign root_sq  = sq_q - {{(WIDTH-RW-1){1'b0}}, delta_q} + {{WIDTH{1'b0}}, 1'b0} + (WIDTH+1)'(2);
    assign rem_full = {1'b0, n_q} - root_sq;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            n_q     <= '0;
            root_q  <= '0;
            sq_q    <= '0;
            delta_q <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            root_o  <= '0;
`ifdef SQRT_REMAINDER_EN
            rem_o   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        n_q     <= n_i;
                        state_q <= StInit;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                StInit: begin
                    root_q  <= '0;
                    sq_q    <= (WIDTH+1)'(1);
                    delta_q <= (RW+2)'(3);
                    state_q <= StCmp;
                end
                StCmp: begin
                    if (sq_le_n) begin
                        state_q <= StUpd;
                    end else begin
                        root_o  <= root_q;
`ifdef SQRT_REMAINDER_EN
                        rem_o   <= rem_full[RW:0];
`endif
                        state_q <= StDone;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                StUpd: begin
                    root_q  <= root_q + RW'(1);
                    sq_q    <= sq_q + {{(WIDTH-RW-1){1'b0}}, delta_q};
                    delta_q <= delta_q + (RW+2)'(2);
                    state_q <= StCmp;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                end
                default: begin
                    // Unused encodings fall back to a clean idle.
                    state_q <= StIdle;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_seq_unit.sv
module tb_sqrt_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_in = '0;
    logic        ready, busy, done;
    logic [7:0]  root;
    logic [8:0]  rem;

    logic        start4 = 1'b0;
    logic [3:0]  n4 = '0;
    logic        ready4, busy4, done4;
    logic [1:0]  root4;
    logic [2:0]  rem4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sqrt_seq_unit #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .n_i     (n_in),
        .ready_o (ready),
        .busy_o  (busy),
        .done_o  (done),
        .root_o  (root)
`ifdef SQRT_REMAINDER_EN
        ,
        .rem_o   (rem)
`endif
    );

    sqrt_seq_unit #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start4),
        .n_i     (n4),
        .ready_o (ready4),
        .busy_o  (busy4),
        .done_o  (done4),
        .root_o  (root4)
`ifdef SQRT_REMAINDER_EN
        ,
        .rem_o   (rem4)
`endif
    );

`ifndef SQRT_REMAINDER_EN
    assign rem  = '0;
    assign rem4 = '0;
`endif

    function automatic int isqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Timing/result model: a request of root R is busy for 2R+2 cycles, then done for one.
    logic       m_idle = 1'b1;
    logic       m_done = 1'b0;
    int         m_left = 0;
    logic [7:0] m_root = '0, m_pend_root = '0;
    logic [8:0] m_rem = '0, m_pend_rem = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_left <= 0;
            m_root <= '0;
            m_rem  <= '0;
        end else if (m_idle) begin
            if (start) begin
                m_pend_root <= 8'(isqrt(int'(n_in)));
                m_pend_rem  <= 9'(int'(n_in) - isqrt(int'(n_in)) * isqrt(int'(n_in)));
                m_left      <= 2 * isqrt(int'(n_in)) + 2;
                m_idle      <= 1'b0;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_root <= m_pend_root;
                m_rem  <= m_pend_rem;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_ready", ready, m_idle);
        chk("cyc_busy", busy, !m_idle && !m_done);
        chk("cyc_done", done, m_done);
        chk("cyc_root", root, m_root);
`ifdef SQRT_REMAINDER_EN
        chk("cyc_rem", rem, m_rem);
`endif
    end

    // Waits for idle, presents n, returns at the negedge after the accepting edge.
    task automatic launch(input logic [15:0] n, input bit hold);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (w >= 600) chk("ready_timeout", ready, 1);
        start = 1'b1;
        n_in  = n;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int first, output int edges);
        edges = first;
        while (!done && edges < 600) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("done_seen", done, 1);
    endtask

    task automatic req(input logic [15:0] n, input int er, input int erem, input int eedges);
        int e;
        launch(n, 1'b0);
        wait_done(1, e);
        chk("latency", e, eedges);
        chk("root", root, er);
`ifdef SQRT_REMAINDER_EN
        chk("rem", rem, erem);
`endif
    endtask

    initial begin
        int e, idle_cnt, w, r;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;

        // Idle after reset with no request.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_ready", ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_root", root, 0);
        end

        req(16'd16, 4, 0, 11);
        req(16'd15, 3, 6, 9);
        req(16'd0, 0, 0, 3);
        req(16'd65535, 255, 510, 513);

        // A start pulse during computation must be ignored.
        launch(16'd100, 1'b0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1;
        n_in  = 16'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_in  = 16'd0;
        wait_done(6, e);
        chk("ign_latency", e, 23);
        chk("ign_root", root, 10);
        @(posedge clk);
        @(negedge clk);
        chk("ign_ready_after", ready, 1);

        // Back-to-back with start held high.
        launch(16'd49, 1'b1);
        wait_done(1, e);
        chk("b2b_lat1", e, 17);
        chk("b2b_root1", root, 7);
`ifdef SQRT_REMAINDER_EN
        chk("b2b_rem1", rem, 0);
`endif
        n_in = 16'd50;
        idle_cnt = 0;
        w = 0;
        @(negedge clk);
        while (!done && w < 600) begin
            if (ready) idle_cnt++;
            @(negedge clk);
            w++;
        end
        chk("b2b_done2", done, 1);
        chk("b2b_idle_cycles", idle_cnt, 1);
        chk("b2b_root2", root, 7);
`ifdef SQRT_REMAINDER_EN
        chk("b2b_rem2", rem, 1);
`endif
        start = 1'b0;

        // Reset while iterating on n=1000.
        launch(16'd1000, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_root", root, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        req(16'd4, 2, 0, 7);

        // Exhaustive sweep of the 4-bit instance.
        for (int n = 0; n < 16; n++) begin
            r = isqrt(n);
            @(negedge clk);
            chk("w4_ready", ready4, 1);
            start4 = 1'b1;
            n4     = 4'(n);
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            e = 1;
            while (!done4 && e < 50) begin
                @(posedge clk);
                e++;
                @(negedge clk);
            end
            chk("w4_done", done4, 1);
            chk("w4_latency", e, 2 * r + 3);
            chk("w4_root", root4, r);
`ifdef SQRT_REMAINDER_EN
            chk("w4_rem", rem4, n - r * r);
`endif
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
